// File: rtl/div_pkg.sv
// Shared types, constants and sign helpers for the RV32M iterative divider.
package div_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {DIV, DIVU, REM, REMU} div_op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

   localparam logic [XLEN-1:0] DIV_ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] DIV_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic is_signed_op(input div_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_rem_op(input div_op_e op);
      return (op == REM) || (op == REMU);
   endfunction

   // INT_MIN maps onto itself, which is its correct unsigned magnitude.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic is_signed);
      return (is_signed && x[XLEN-1]) ? (~x + 1'b1) : x;
   endfunction

   function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] x, input logic en);
      return en ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with start/busy/valid
// handshake; the result drives the regfile write port for one cycle.
module div_unit #(
   parameter int XLEN = div_pkg::XLEN
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic [4:0]      i_rd_addr,
   input  logic            i_flush,
   output logic            o_busy,
   output logic            o_valid,
   output logic [4:0]      o_rd_addr,
   output logic [XLEN-1:0] o_rd_data,
   output logic            o_rd_wren
);

   import div_pkg::*;

   localparam int CNT_W = $clog2(XLEN);

   div_state_e       state_q, state_d;
   div_op_e          op_q, op_d;
   logic [4:0]       dst_q, dst_d;
   logic [4:0]       rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]  rd_data_q, rd_data_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  dvsr_q, dvsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;

   // Request decode.
   div_op_e req_op;
   logic    req_signed, req_rem, div_by_zero, overflow, accept;

   assign req_op      = div_op_e'(i_op);
   assign req_signed  = is_signed_op(req_op);
   assign req_rem     = is_rem_op(req_op);
   assign div_by_zero = (i_rs2_data == '0);
   assign overflow    = req_signed && (i_rs1_data == DIV_INT_MIN) && (i_rs2_data == DIV_ALL_ONES);
   assign accept      = i_start && !i_flush && ((state_q == IDLE) || (state_q == DONE));

   // One restoring step. The shifted partial remainder keeps its carry-out bit
   // so divisors with the MSB set still compare correctly.
   logic [XLEN:0]   rem_sh;
   logic            fits;
   logic [XLEN-1:0] diff, quo_step, rem_step, final_res;

   assign rem_sh    = {rem_q, quo_q[XLEN-1]};
   assign fits      = rem_sh[XLEN] || (rem_sh[XLEN-1:0] >= dvsr_q);
   assign diff      = rem_sh[XLEN-1:0] - dvsr_q;
   assign quo_step  = {quo_q[XLEN-2:0], fits};
   assign rem_step  = fits ? diff : rem_sh[XLEN-1:0];
   assign final_res = is_rem_op(op_q) ? cond_negate(rem_step, neg_rem_q)
                                      : cond_negate(quo_step, neg_quo_q);

   // NOTE: every _d gets its hold value first so no path leaves a latch behind.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      dst_d     = dst_q;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvsr_d    = dvsr_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;

      if (i_flush) begin
         state_d = IDLE;
      end else if (accept) begin
         op_d  = req_op;
         dst_d = i_rd_addr;
         if (div_by_zero || overflow) begin
            state_d   = DONE;
            rd_addr_d = i_rd_addr;
            if (div_by_zero)
               rd_data_d = req_rem ? i_rs1_data : DIV_ALL_ONES;
            else
               rd_data_d = req_rem ? '0 : DIV_INT_MIN;
         end else begin
            state_d   = CALC;
            quo_d     = magnitude(i_rs1_data, req_signed);
            dvsr_d    = magnitude(i_rs2_data, req_signed);
            rem_d     = '0;
            cnt_d     = CNT_W'(XLEN - 1);
            neg_quo_d = req_signed && (i_rs1_data[XLEN-1] ^ i_rs2_data[XLEN-1]);
            neg_rem_d = req_signed && i_rs1_data[XLEN-1];
         end
      end else begin
         case (state_q)
            CALC: begin
               quo_d = quo_step;
               rem_d = rem_step;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d   = DONE;
                  rd_addr_d = dst_q;
                  rd_data_d = final_res;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= IDLE;
         op_q      <= DIV;
         dst_q     <= '0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvsr_q    <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         dst_q     <= dst_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvsr_q    <= dvsr_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign o_busy    = (state_q == CALC);
   assign o_valid   = (state_q == DONE);
   assign o_rd_wren = o_valid;
   assign o_rd_addr = rd_addr_q;
   assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares on every o_valid.
module tb_div_unit;

   import div_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  rd = '0;

   logic        o_busy, o_valid, o_rd_wren;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;

   div_unit #(.XLEN(32)) dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_start    (start),
      .i_op       (op),
      .i_rs1_data (a),
      .i_rs2_data (b),
      .i_rd_addr  (rd),
      .i_flush    (flush),
      .o_busy     (o_busy),
      .o_valid    (o_valid),
      .o_rd_addr  (o_rd_addr),
      .o_rd_data  (o_rd_data),
      .o_rd_wren  (o_rd_wren)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (o_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_valid", 32'(o_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check("rd_data", o_rd_data, e.data);
            check("rd_addr", 32'(o_rd_addr), 32'(e.addr));
            check("rd_wren", 32'(o_rd_wren), 32'd1);
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input logic [31:0] e, input bit push);
      op = o; a = x; b = y; rd = r; start = 1'b1;
      if (push) sb.push_back('{addr: r, data: e});
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts edges after accept until o_valid, and cycles spent busy.
   task automatic wait_valid(input string tag, input int exp_edges, input int exp_busy, input bit hold);
      int n    = 0;
      int busy = 0;
      bit seen = 1'b0;
      if (hold) begin
         start = 1'b1; op = DIVU; a = 32'd999; b = 32'd3; rd = 5'd31;
      end
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (o_busy) busy++;
         if (o_valid) seen = 1'b1;
         if (hold && n == 20) start = 1'b0;
      end
      start = 1'b0;
      check({tag, "_valid_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, n - 1, exp_edges);
      check({tag, "_busy_cycles"}, busy, exp_busy);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"},    32'(o_busy),    32'd0);
      check({tag, "_valid"},   32'(o_valid),   32'd0);
      check({tag, "_wren"},    32'(o_rd_wren), 32'd0);
      check({tag, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
      check({tag, "_rd_data"}, o_rd_data,      32'd0);
   endtask

   task automatic quiet_window(input string tag, input int cycles);
      int v = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (o_valid) v++;
      end
      check({tag, "_no_valid"}, v, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      #12 check_zero_outputs("reset");
      #5 rst_n = 1'b1;
      @(posedge clk); #1;

      issue(DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 1);
      wait_valid("divu_100_7", 32, 32, 0);
      issue(DIV, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFA, 1);
      wait_valid("div_m20_3", 32, 32, 0);
      issue(REM, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFE, 1);
      wait_valid("rem_m20_3", 32, 32, 0);
      issue(REMU, 32'd20, 32'hFFFF_FFFD, 5'd8, 32'd20, 1);
      wait_valid("remu_20_big", 32, 32, 0);

      issue(DIV, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
      wait_valid("div_by_zero", 0, 0, 0);
      issue(REMU, 32'd5, 32'd0, 5'd10, 32'd5, 1);
      wait_valid("remu_by_zero", 0, 0, 0);
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
      wait_valid("div_overflow", 0, 0, 0);
      issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);
      wait_valid("rem_overflow", 0, 0, 0);
      // Unsigned view: 2^31 / (2^32-1) is 0 remainder 2^31, full iteration.
      issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);
      wait_valid("divu_intmin", 32, 32, 0);
      issue(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
      wait_valid("remu_intmin", 32, 32, 0);

      issue(DIVU, 32'd7, 32'd2, 5'd0, 32'd3, 1);
      wait_valid("rd_zero", 32, 32, 0);

      // Flush mid-CALC; a start presented alongside the flush is dropped.
      issue(DIVU, 32'd1000, 32'd10, 5'd3, 32'd0, 0);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1; start = 1'b1; op = DIVU; a = 32'd7; b = 32'd1; rd = 5'd4;
      @(posedge clk);
      #1 flush = 1'b0; start = 1'b0;
      check("flush_busy",  32'(o_busy),  32'd0);
      check("flush_valid", 32'(o_valid), 32'd0);
      quiet_window("flush", 40);

      // Reset mid-CALC returns everything to zero without waiting for a clock.
      @(posedge clk); #1;
      issue(DIVU, 32'd1000, 32'd10, 5'd2, 32'd0, 0);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("async_reset");
      #3 rst_n = 1'b1;
      quiet_window("reset", 40);

      @(posedge clk); #1;
      issue(DIVU, 32'd1000, 32'd10, 5'd12, 32'd100, 1);
      wait_valid("divu_1000_10", 32, 32, 0);

      // Back-to-back: second op issued during the first op's DONE cycle,
      // then start held through part of its CALC with junk operands.
      issue(DIV, 32'd100, 32'hFFFF_FFF9, 5'd15, 32'hFFFF_FFF2, 1);
      wait_valid("b2b_first", 32, 32, 0);
      issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFD, 1);
      wait_valid("b2b_second", 32, 32, 1);
      repeat (3) @(negedge clk);
      check("after_b2b_busy", 32'(o_busy), 32'd0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
